// File: rtl/mem_bus_master.sv
// Memory bus initiator: sequences valid/ready requests into addr/read/write strobe cycles on a tri-state data bus.
// Optional MEM_BUS_WRITE_VERIFY_EN: every write is read back and verify_err_o pulses with rsp_valid_o on mismatch.
module mem_bus_master #(
  parameter int AW       = 5,
  parameter int DW       = 8,
  parameter int RD_WAIT  = 1,
  parameter int WR_PULSE = 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          req_valid_i,
  output logic          req_ready_o,
  input  logic          req_write_i,
  input  logic [AW-1:0] req_addr_i,
  input  logic [DW-1:0] req_wdata_i,
  output logic          rsp_valid_o,
  output logic [DW-1:0] rsp_rdata_o,
  output logic [AW-1:0] mem_addr_o,
  output logic          mem_read_o,
  output logic          mem_write_o,
`ifdef MEM_BUS_WRITE_VERIFY_EN
  output logic          verify_err_o,
`endif
  inout  wire  [DW-1:0] mem_data_io
);

  typedef enum logic [2:0] {
    IDLE, WR_SETUP, WR_STB, WR_HOLD, RD_STB, RD_SAMPLE, TURN
  } state_t;

  localparam int CMAX = (RD_WAIT > WR_PULSE) ? RD_WAIT : WR_PULSE;
  localparam int CW   = $clog2(CMAX + 1);
  localparam logic [CW-1:0] RD_LOAD = CW'(RD_WAIT - 1);
  localparam logic [CW-1:0] WR_LOAD = CW'(WR_PULSE - 1);

  state_t        state_q;
  logic [CW-1:0] cnt_q;
  logic          req_ready_q;
  logic          rsp_valid_q;
  logic [DW-1:0] rsp_rdata_q;
  logic [AW-1:0] mem_addr_q;
  logic          mem_read_q;
  logic          mem_write_q;
  logic          oe_q;
  logic [DW-1:0] wdata_q;
`ifdef MEM_BUS_WRITE_VERIFY_EN
  logic          is_write_q;
  logic          verr_pend_q;
  logic          verify_err_q;
`endif

  wire accept = req_valid_i && req_ready_q && (state_q == IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      req_ready_q  <= 1'b0;
      rsp_valid_q  <= 1'b0;
      rsp_rdata_q  <= '0;
      mem_addr_q   <= '0;
      mem_read_q   <= 1'b0;
      mem_write_q  <= 1'b0;
      oe_q         <= 1'b0;
      wdata_q      <= '0;
`ifdef MEM_BUS_WRITE_VERIFY_EN
      is_write_q   <= 1'b0;
      verr_pend_q  <= 1'b0;
      verify_err_q <= 1'b0;
`endif
    end else begin
      rsp_valid_q  <= 1'b0;
`ifdef MEM_BUS_WRITE_VERIFY_EN
      verify_err_q <= 1'b0;
`endif
      case (state_q)
        IDLE: begin
          if (accept) begin
            req_ready_q <= 1'b0;
            mem_addr_q  <= req_addr_i;
            wdata_q     <= req_wdata_i;
`ifdef MEM_BUS_WRITE_VERIFY_EN
            is_write_q  <= req_write_i;
`endif
            if (req_write_i) begin
              state_q <= WR_SETUP;
              oe_q    <= 1'b1;
            end else begin
              state_q    <= RD_STB;
              mem_read_q <= 1'b1;
              cnt_q      <= RD_LOAD;
            end
          end else begin
            req_ready_q <= 1'b1;
          end
        end
        WR_SETUP: begin
          state_q     <= WR_STB;
          mem_write_q <= 1'b1;
          cnt_q       <= WR_LOAD;
        end
        WR_STB: begin
          if (cnt_q == '0) begin
            state_q     <= WR_HOLD;
            mem_write_q <= 1'b0;
          end else begin
            cnt_q <= cnt_q - CW'(1);
          end
        end
        WR_HOLD: begin
          oe_q <= 1'b0;
`ifdef MEM_BUS_WRITE_VERIFY_EN
          // Bus is released on the same edge the read strobe rises; never both active.
          state_q    <= RD_STB;
          mem_read_q <= 1'b1;
          cnt_q      <= RD_LOAD;
`else
          state_q     <= IDLE;
          rsp_valid_q <= 1'b1;
          req_ready_q <= 1'b1;
`endif
        end
        RD_STB: begin
          if (cnt_q == '0) state_q <= RD_SAMPLE;
          else             cnt_q   <= cnt_q - CW'(1);
        end
        RD_SAMPLE: begin
          state_q    <= TURN;
          mem_read_q <= 1'b0;
`ifdef MEM_BUS_WRITE_VERIFY_EN
          if (!is_write_q) rsp_rdata_q <= mem_data_io;
          verr_pend_q <= is_write_q && (mem_data_io != wdata_q);
`else
          rsp_rdata_q <= mem_data_io;
`endif
        end
        TURN: begin
          state_q     <= IDLE;
          rsp_valid_q <= 1'b1;
          req_ready_q <= 1'b1;
`ifdef MEM_BUS_WRITE_VERIFY_EN
          verify_err_q <= verr_pend_q;
`endif
        end
        default: begin
          state_q     <= IDLE;
          mem_read_q  <= 1'b0;
          mem_write_q <= 1'b0;
          oe_q        <= 1'b0;
          req_ready_q <= 1'b1;
        end
      endcase
    end
  end

  assign req_ready_o = req_ready_q;
  assign rsp_valid_o = rsp_valid_q;
  assign rsp_rdata_o = rsp_rdata_q;
  assign mem_addr_o  = mem_addr_q;
  assign mem_read_o  = mem_read_q;
  assign mem_write_o = mem_write_q;
  assign mem_data_io = oe_q ? wdata_q : {DW{1'bz}};
`ifdef MEM_BUS_WRITE_VERIFY_EN
  assign verify_err_o = verify_err_q;
`endif

  a_oe_read:    assert property (@(posedge clk) disable iff (!rst_n) !(oe_q && mem_read_q));
  a_read_write: assert property (@(posedge clk) disable iff (!rst_n) !(mem_read_q && mem_write_q));
  a_wr_oe_rise: assert property (@(posedge clk) disable iff (!rst_n) !($rose(mem_write_q) && $rose(oe_q)));

endmodule

// File: tb/tb_mem_bus_master.sv
// Directed bench for mem_bus_master: vector table of reads/writes against a 32x8 memory model,
// plus reset-mid-write, busy-hold and (with MEM_BUS_WRITE_VERIFY_EN) write-verify sequences.
module tb_mem_bus_master;

`ifdef MEM_BUS_WRITE_VERIFY_EN
  localparam int WLAT = 6;
`else
  localparam int WLAT = 3;
`endif
  localparam int RLAT = 3;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       req_valid = 1'b0;
  logic       req_write = 1'b0;
  logic [4:0] req_addr = '0;
  logic [7:0] req_wdata = '0;
  logic       req_ready, rsp_valid, mem_read, mem_write;
  logic [7:0] rsp_rdata;
  logic [4:0] mem_addr;
  wire  [7:0] mem_data;
`ifdef MEM_BUS_WRITE_VERIFY_EN
  logic       verify_err;
  logic       exp_verr = 1'b0;
`endif

  logic       probe_en = 1'b0;
  logic       stuck_en = 1'b0;
  logic [7:0] mem [32];
  logic [7:0] hold_rd = 8'h00;
  int         n_vec = 0;
  int         n_err = 0;

  mem_bus_master dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .req_valid_i (req_valid),
    .req_ready_o (req_ready),
    .req_write_i (req_write),
    .req_addr_i  (req_addr),
    .req_wdata_i (req_wdata),
    .rsp_valid_o (rsp_valid),
    .rsp_rdata_o (rsp_rdata),
    .mem_addr_o  (mem_addr),
    .mem_read_o  (mem_read),
    .mem_write_o (mem_write),
`ifdef MEM_BUS_WRITE_VERIFY_EN
    .verify_err_o(verify_err),
`endif
    .mem_data_io (mem_data)
  );

  always #5 clk = ~clk;

  // Memory drives the bus while read is high; the probe drives a known pattern to show release.
  assign mem_data = mem_read ? mem[mem_addr] : (probe_en ? 8'h5A : 8'hzz);

  always @(posedge clk)
    if (mem_write)
      mem[mem_addr] <= (stuck_en && mem_addr == 5'd3) ? (mem_data & 8'hFE) : mem_data;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  logic prev_mw = 1'b0, prev_oe = 1'b0;
  always @(negedge clk) begin
    if (rst_n) begin
      check("inv_oe_read", 32'(dut.oe_q & mem_read), 32'd0);
      check("inv_read_write", 32'(mem_read & mem_write), 32'd0);
      check("inv_wr_oe_rise", 32'(mem_write & ~prev_mw & dut.oe_q & ~prev_oe), 32'd0);
    end
    prev_mw <= rst_n & mem_write;
    prev_oe <= rst_n & dut.oe_q;
  end

  // Called at a negedge; drives the request, waits for acceptance and the response.
  task automatic do_req(input logic wr, input logic [4:0] a, input logic [7:0] d,
                        input logic [7:0] exp_rd, input string tag);
    int lat, wp, g, exp_lat;
    exp_lat = wr ? WLAT : RLAT;
    req_valid = 1'b1; req_write = wr; req_addr = a; req_wdata = d;
    g = 0;
    while (!req_ready && g < 20) begin @(negedge clk); g++; end
    check({tag, "_ready"}, 32'(req_ready), 32'd1);
    if (!req_ready) begin req_valid = 1'b0; return; end
    @(posedge clk); #1 req_valid = 1'b0;
    lat = 0; wp = 0;
    forever begin
      @(negedge clk);
      if (rsp_valid || lat >= 40) break;
      if (wr && lat == 0)
        check({tag, "_setup"}, 32'({mem_write, dut.oe_q, mem_data == d}), 32'b011);
      if (dut.oe_q) check({tag, "_wdata"}, 32'(mem_data), 32'(d));
      if (mem_read || mem_write) check({tag, "_addr"}, 32'(mem_addr), 32'(a));
      if (mem_write) wp++;
      if (!wr && lat < RLAT - 1) check({tag, "_rdstb"}, 32'(mem_read), 32'd1);
      if (lat == exp_lat - 1) begin
`ifdef MEM_BUS_WRITE_VERIFY_EN
        check({tag, "_turn"}, 32'({mem_read, dut.oe_q, mem_write}), 32'b000);
`else
        if (wr) check({tag, "_hold"}, 32'({mem_write, dut.oe_q}), 32'b01);
        else    check({tag, "_turn"}, 32'({mem_read, dut.oe_q, mem_write}), 32'b000);
`endif
      end
      @(posedge clk); lat++;
    end
    check({tag, "_latency"}, 32'(lat), 32'(exp_lat));
    if (!wr) hold_rd = exp_rd;
    check({tag, "_rdata"}, 32'(rsp_rdata), 32'(hold_rd));
    check({tag, "_wpulse"}, 32'(wp), wr ? 32'd1 : 32'd0);
`ifdef MEM_BUS_WRITE_VERIFY_EN
    check({tag, "_verr"}, 32'(verify_err), 32'(wr & exp_verr));
`endif
  endtask

  typedef struct {
    logic       wr;
    logic [4:0] addr;
    logic [7:0] wdata;
    logic [7:0] exp_rd;
  } vec_t;
  vec_t vecs[67];

  initial begin
    int rcnt, r1, r2, acc2;
    logic acc_next;
    logic [7:0] rdat;

    for (int i = 0; i < 32; i++) begin
      vecs[i]      = '{1'b1, 5'(i), 8'(i), 8'h00};
      vecs[32 + i] = '{1'b0, 5'(i), 8'h00, 8'(i)};
    end
    vecs[64] = '{1'b0, 5'd5, 8'h00, 8'h05};
    vecs[65] = '{1'b1, 5'd5, 8'hA5, 8'h00};
    vecs[66] = '{1'b0, 5'd5, 8'h00, 8'hA5};

    // Reset values
    repeat (2) @(negedge clk);
    check("rst_ctrl", 32'({req_ready, rsp_valid, mem_read, mem_write, dut.oe_q}), 32'd0);
    check("rst_rdata", 32'(rsp_rdata), 32'd0);
    check("rst_addr", 32'(mem_addr), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    check("rst_ready_after", 32'(req_ready), 32'd1);

    // Reset asserted in the middle of WR_STB
    req_valid = 1'b1; req_write = 1'b1; req_addr = 5'd9; req_wdata = 8'hC3;
    @(posedge clk); #1 req_valid = 1'b0;
    repeat (2) @(negedge clk);
    check("midrst_in_wrstb", 32'(mem_write), 32'd1);
    rst_n = 1'b0; probe_en = 1'b1;
    #1;
    check("midrst_ctrl", 32'({mem_write, mem_read, rsp_valid, req_ready, dut.oe_q}), 32'd0);
    check("midrst_bus_free", 32'(mem_data), 32'h5A);
    @(negedge clk); probe_en = 1'b0; rst_n = 1'b1;
    @(posedge clk); #1;
    check("midrst_ready", 32'(req_ready), 32'd1);
    rcnt = 0;
    repeat (5) begin @(negedge clk); if (rsp_valid) rcnt++; end
    check("midrst_no_rsp", 32'(rcnt), 32'd0);
    hold_rd = 8'h00;

    // Vector table: write sweep, read sweep, read/write turnaround
    for (int i = 0; i < 67; i++)
      do_req(vecs[i].wr, vecs[i].addr, vecs[i].wdata, vecs[i].exp_rd, $sformatf("v%0d", i));

    // Busy hold: valid stays high across a write then a read
    req_valid = 1'b1; req_write = 1'b1; req_addr = 5'd7; req_wdata = 8'h3C;
    @(posedge clk); #1 req_write = 1'b0;
    acc_next = 1'b0; r1 = -1; r2 = -1; acc2 = -1; rcnt = 0; rdat = 8'h00;
    for (int k = 1; k <= 20; k++) begin
      @(posedge clk);
      if (acc_next) begin acc2 = k; acc_next = 1'b0; #1 req_valid = 1'b0; end
      @(negedge clk);
      if (req_valid && req_ready) acc_next = 1'b1;
      if (rsp_valid) begin
        rcnt++;
        if (r1 < 0) r1 = k; else r2 = k;
        rdat = rsp_rdata;
      end
    end
    req_valid = 1'b0;
    check("busy_wr_rsp", 32'(r1), 32'(WLAT));
    check("busy_rd_accept", 32'(acc2), 32'(WLAT + 1));
    check("busy_rd_rsp", 32'(r2), 32'(WLAT + 1 + RLAT));
    check("busy_rsp_count", 32'(rcnt), 32'd2);
    check("busy_rdata", 32'(rdat), 32'h3C);
    hold_rd = 8'h3C;

`ifdef MEM_BUS_WRITE_VERIFY_EN
    // Bit 0 of address 3 stuck at zero
    stuck_en = 1'b1;
    exp_verr = 1'b1;
    do_req(1'b1, 5'd3, 8'h01, 8'h00, "verify_bad");
    exp_verr = 1'b0;
    do_req(1'b1, 5'd3, 8'h02, 8'h00, "verify_good");
    stuck_en = 1'b0;
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got no finish, expected finish");
    $fatal(1);
  end

endmodule
